// File: rtl/fp_display_scan_mux.sv
// Front-panel display source selector: registers NCH channel taps and drives the lamp
// word from one of them, either by manual one-hot select or by timed auto-scan rotation.
module fp_display_scan_mux #(
    parameter int WIDTH = 12,
    parameter int NCH   = 6,
    parameter int DWELL = 4000000,
    parameter int DW    = 23,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [NCH-1:0]       dsel,
    input  logic                 scan_en,
    input  logic                 freeze,
    input  logic [1:0]           run_state,
    output logic [WIDTH-1:0]     dout,
    output logic [CW-1:0]        chan,
    output logic                 valid,
    output logic                 run_led
);

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t                      state_q, state_d;
    logic [NCH-1:0][WIDTH-1:0]   cap_q, cap_d;
    logic [WIDTH-1:0]            dout_q, dout_d;
    logic [CW-1:0]               chan_q, chan_d;
    logic                        valid_q, valid_d;
    logic                        run_led_q, run_led_d;
    logic [CW-1:0]               ptr_q, ptr_d;
    logic [DW-1:0]               cnt_q, cnt_d;

    logic [NCH-1:0]              mask;
    logic [CW-1:0]               sel_idx;
    logic [CW-1:0]               first_idx;
    logic [CW-1:0]               next_idx;

    function automatic logic [CW-1:0] hi_bit(input logic [NCH-1:0] v);
        hi_bit = '0;
        for (int i = 0; i < NCH; i++)
            if (v[i]) hi_bit = CW'(i);
    endfunction

    // First set bit of m at or after start, wrapping NCH-1 -> 0. Reverse scan so the
    // nearest candidate is the last one written.
    function automatic logic [CW-1:0] first_from(input logic [NCH-1:0] m, input int start);
        int idx;
        first_from = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = start + i;
            if (idx >= NCH) idx = idx - NCH;
            if (m[idx]) first_from = CW'(idx);
        end
    endfunction

    always_comb begin
        mask      = (dsel == '0) ? '1 : dsel;
        sel_idx   = hi_bit(dsel);
        first_idx = first_from(mask, 0);
        next_idx  = first_from(mask, (int'(ptr_q) == NCH - 1) ? 0 : int'(ptr_q) + 1);
    end

    always_comb begin
        state_d   = state_q;
        cap_d     = freeze ? cap_q : din;
        dout_d    = '0;
        chan_d    = '0;
        valid_d   = 1'b0;
        run_led_d = (run_state != 2'b11);
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            MANUAL: begin
                if (dsel != '0) begin
                    dout_d  = cap_q[sel_idx];
                    chan_d  = sel_idx;
                    valid_d = 1'b1;
                end
                if (scan_en) begin
                    state_d = SCAN;
                    ptr_d   = first_idx;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                dout_d  = cap_q[ptr_q];
                chan_d  = ptr_q;
                valid_d = 1'b1;
                if (!scan_en) begin
                    state_d = MANUAL;
                    cnt_d   = '0;
                end else if (!mask[ptr_q] || cnt_q == DW'(DWELL - 1)) begin
                    // A channel dropped from the mask mid-dwell is abandoned immediately.
                    ptr_d = next_idx;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MANUAL;
            cap_q     <= '0;
            dout_q    <= '0;
            chan_q    <= '0;
            valid_q   <= 1'b0;
            run_led_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            dout_q    <= dout_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            run_led_q <= run_led_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dout    = dout_q;
    assign chan    = chan_q;
    assign valid   = valid_q;
    assign run_led = run_led_q;

endmodule
